// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores over a req/ack data port, holds the
// upstream stages while an access is in flight, and hands a valid-qualified
// write-back bundle to MEM/WB. Non-memory instructions pass straight through.
module mem_access_stage #(
    parameter int DSIZE   = 32,
    parameter int ASIZE   = 5,
    parameter int ISIZE   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             MemRead_in,
    input  logic             MemWrite_in,
    input  logic [DSIZE-1:0] alu_result_in,
    input  logic [DSIZE-1:0] store_data_in,
    input  logic [ASIZE-1:0] w_addr_in,
    input  logic             wen_in,
    input  logic             MemtoReg_in,
    input  logic [ISIZE-1:0] PC_in,
    output logic             mem_req,
    output logic             mem_we,
    output logic [DSIZE-1:0] mem_addr,
    output logic [DSIZE-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [DSIZE-1:0] mem_rdata,
    output logic             stall_out,
    output logic             valid_out,
    output logic [DSIZE-1:0] w_data_out,
    output logic [ASIZE-1:0] w_addr_out,
    output logic             wen_out,
    output logic             MemtoReg_out,
    output logic [DSIZE-1:0] readMem_out,
    output logic [ISIZE-1:0] PC_out,
    output logic             misalign_err,
    output logic             bus_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [DSIZE-1:0] addr_q, addr_d;
    logic [DSIZE-1:0] wdata_q, wdata_d;
    logic [DSIZE-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             mis_q, mis_d;
    logic             bus_q, bus_d;

    logic mem_op;
    logic misaligned;

    assign mem_op     = MemRead_in | MemWrite_in;
    assign misaligned = (alu_result_in[1:0] != 2'b00);

    // State and access registers; reset abandons any in-flight access at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            bus_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
            bus_q   <= bus_d;
        end
    end

    // Next-state: launch aligned accesses, wait for ack or time out, one DONE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mis_d   = 1'b0;
        bus_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_in && mem_op) begin
                    if (misaligned) begin
                        mis_d = 1'b1;
                    end else begin
                        // A read/write conflict resolves to a read.
                        we_d    = MemWrite_in & ~MemRead_in;
                        addr_d  = alu_result_in;
                        wdata_d = store_data_in;
                        rdata_d = '0;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_ack) begin
                    rdata_d = we_q ? '0 : mem_rdata;
                    state_d = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    bus_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and write-back outputs; everything is quiet while reset is held.
    always_comb begin
        stall_out   = 1'b0;
        valid_out   = 1'b0;
        wen_out     = 1'b0;
        readMem_out = '0;
        unique case (state_q)
            IDLE: begin
                stall_out = valid_in & mem_op & ~misaligned;
                valid_out = valid_in & ~(mem_op & ~misaligned);
                wen_out   = valid_in & wen_in & ~mem_op;
            end
            BUSY: begin
                stall_out = 1'b1;
            end
            DONE: begin
                valid_out   = 1'b1;
                wen_out     = wen_in & ~err_q;
                readMem_out = rdata_q;
            end
            default: begin
                stall_out = 1'b0;
            end
        endcase
        if (!rst) begin
            stall_out = 1'b0;
            valid_out = 1'b0;
            wen_out   = 1'b0;
        end
    end

    assign mem_req      = (state_q == BUSY);
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign misalign_err = mis_q;
    assign bus_err      = bus_q;

    assign w_data_out   = alu_result_in;
    assign w_addr_out   = w_addr_in;
    assign MemtoReg_out = MemtoReg_in;
    assign PC_out       = PC_in;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed transactions push expected write-back
// bundles into a queue; a monitor pops and compares whenever valid_out is seen.
module tb_mem_access_stage;

    localparam int DSIZE   = 32;
    localparam int ASIZE   = 5;
    localparam int ISIZE   = 32;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid_in, MemRead_in, MemWrite_in;
    logic [DSIZE-1:0] alu_result_in, store_data_in;
    logic [ASIZE-1:0] w_addr_in;
    logic             wen_in, MemtoReg_in;
    logic [ISIZE-1:0] PC_in;
    logic             mem_req, mem_we;
    logic [DSIZE-1:0] mem_addr, mem_wdata;
    logic             mem_ack;
    logic [DSIZE-1:0] mem_rdata;
    logic             stall_out, valid_out;
    logic [DSIZE-1:0] w_data_out;
    logic [ASIZE-1:0] w_addr_out;
    logic             wen_out, MemtoReg_out;
    logic [DSIZE-1:0] readMem_out;
    logic [ISIZE-1:0] PC_out;
    logic             misalign_err, bus_err;

    always #5 clk = ~clk;

    mem_access_stage #(
        .DSIZE(DSIZE), .ASIZE(ASIZE), .ISIZE(ISIZE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst_n),
        .valid_in(valid_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .alu_result_in(alu_result_in), .store_data_in(store_data_in),
        .w_addr_in(w_addr_in), .wen_in(wen_in), .MemtoReg_in(MemtoReg_in),
        .PC_in(PC_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_out(stall_out), .valid_out(valid_out),
        .w_data_out(w_data_out), .w_addr_out(w_addr_out), .wen_out(wen_out),
        .MemtoReg_out(MemtoReg_out), .readMem_out(readMem_out), .PC_out(PC_out),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    typedef struct {
        logic [31:0] w_data;
        logic [4:0]  w_addr;
        logic        wen;
        logic        m2r;
        logic [31:0] rd;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          stall_cnt, req_cnt, mis_cnt, bus_cnt;
    logic [31:0] exp_mem_addr, exp_mem_wdata;
    logic        exp_mem_we;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: counts pulse/stall cycles, checks the latched bus, pops on valid_out.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_out)    stall_cnt++;
            if (mem_req)      req_cnt++;
            if (misalign_err) mis_cnt++;
            if (bus_err)      bus_cnt++;
            if (mem_req) begin
                check("mem_addr",  64'(mem_addr),  64'(exp_mem_addr));
                check("mem_we",    64'(mem_we),    64'(exp_mem_we));
                check("mem_wdata", 64'(mem_wdata), 64'(exp_mem_wdata));
            end
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid_out", 64'(valid_out), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("w_data_out",   64'(w_data_out),   64'(mon_e.w_data));
                    check("w_addr_out",   64'(w_addr_out),   64'(mon_e.w_addr));
                    check("wen_out",      64'(wen_out),      64'(mon_e.wen));
                    check("MemtoReg_out", 64'(MemtoReg_out), 64'(mon_e.m2r));
                    check("readMem_out",  64'(readMem_out),  64'(mon_e.rd));
                    check("PC_out",       64'(PC_out),       64'(mon_e.pc));
                    $display("txn pc=0x%0h w_data=0x%0h rd=0x%0h wen=%0b", PC_out, w_data_out, readMem_out, wen_out);
                end
            end
        end
    end

    task automatic idle_inputs();
        valid_in = 0; MemRead_in = 0; MemWrite_in = 0;
        alu_result_in = '0; store_data_in = '0; w_addr_in = '0;
        wen_in = 0; MemtoReg_in = 0; PC_in = '0;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [31:0] alu,
                          input logic [31:0] sd, input logic [4:0] wa, input logic wen,
                          input logic m2r, input logic [31:0] pc);
        valid_in = 1; MemRead_in = rd; MemWrite_in = wr;
        alu_result_in = alu; store_data_in = sd; w_addr_in = wa;
        wen_in = wen; MemtoReg_in = m2r; PC_in = pc;
    endtask

    task automatic clear_cnts();
        stall_cnt = 0; req_cnt = 0; mis_cnt = 0; bus_cnt = 0;
    endtask

    // Non-memory op: zero-latency pass-through.
    task automatic alu_op(input logic [31:0] alu, input logic [4:0] wa, input logic [31:0] pc);
        clear_cnts();
        exp_q.push_back('{alu, wa, 1'b1, 1'b0, 32'h0, pc});
        set_op(0, 0, alu, 32'h0, wa, 1, 0, pc);
        #3;
        check("alu_stall",   64'(stall_out), 64'(0));
        check("alu_mem_req", 64'(mem_req),   64'(0));
        check("alu_valid",   64'(valid_out), 64'(1));
        @(posedge clk); #1 idle_inputs();
    endtask

    // Aligned access; k<0 means the memory never acks.
    task automatic mem_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [4:0] wa, input logic wen,
                           input logic m2r, input logic [31:0] pc, input int k,
                           input logic [31:0] rdata);
        logic is_store;
        int   exp_stall, exp_req;
        is_store = wr & ~rd;
        clear_cnts();
        exp_mem_addr = addr; exp_mem_we = is_store; exp_mem_wdata = sd;
        exp_q.push_back('{addr, wa, (k >= 0) ? wen : 1'b0, m2r,
                          (k >= 0 && !is_store) ? rdata : 32'h0, pc});
        set_op(rd, wr, addr, sd, wa, wen, m2r, pc);
        if (k >= 0) begin
            repeat (1 + k) @(posedge clk);
            #1 mem_ack = 1; mem_rdata = rdata;
            @(posedge clk);
            #1 mem_ack = 0; mem_rdata = 32'h0BAD_0BAD;
        end else begin
            repeat (1 + TIMEOUT) @(posedge clk);
        end
        @(posedge clk); #1 idle_inputs();
        exp_stall = (k >= 0) ? k + 2 : TIMEOUT + 1;
        exp_req   = (k >= 0) ? k + 1 : TIMEOUT;
        check("stall_cycles",   64'(stall_cnt),    64'(exp_stall));
        check("mem_req_cycles", 64'(req_cnt),      64'(exp_req));
        check("bus_err_pulses", 64'(bus_cnt),      64'((k < 0) ? 1 : 0));
        check("misalign_none",  64'(mis_cnt),      64'(0));
        check("pending_expect", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        rst_n = 0; mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        clear_cnts();
        exp_mem_addr = '0; exp_mem_we = 0; exp_mem_wdata = '0;
        // Live-looking inputs while reset is held must not leak out.
        set_op(1, 0, 32'h100, 32'h55, 5'd1, 1, 0, 32'h10);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",   64'(valid_out),    64'(0));
        check("rst_stall",   64'(stall_out),    64'(0));
        check("rst_wen",     64'(wen_out),      64'(0));
        check("rst_mem_req", 64'(mem_req),      64'(0));
        check("rst_mem_we",  64'(mem_we),       64'(0));
        check("rst_addr",    64'(mem_addr),     64'(0));
        check("rst_wdata",   64'(mem_wdata),    64'(0));
        check("rst_mis",     64'(misalign_err), 64'(0));
        check("rst_bus",     64'(bus_err),      64'(0));
        idle_inputs(); mem_ack = 0; mem_rdata = '0;
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;

        alu_op(32'h0000_0042, 5'd3, 32'h0000_1000);

        // Load, ack two cycles into BUSY.
        mem_txn(1, 0, 32'h0000_0100, 32'h0000_00AA, 5'd5, 1, 1, 32'h0000_1004, 2, 32'hDEAD_BEEF);
        // Store, ack in the first BUSY cycle.
        mem_txn(0, 1, 32'h0000_0204, 32'h1234_5678, 5'd0, 0, 0, 32'h0000_1008, 0, 32'hFFFF_0000);

        // Misaligned load: no request, immediate valid, wen suppressed.
        clear_cnts();
        exp_q.push_back('{32'h0000_0103, 5'd7, 1'b0, 1'b1, 32'h0, 32'h0000_100C});
        set_op(1, 0, 32'h0000_0103, 32'h0, 5'd7, 1, 1, 32'h0000_100C);
        #3;
        check("mis_mem_req", 64'(mem_req),      64'(0));
        check("mis_stall",   64'(stall_out),    64'(0));
        check("mis_early",   64'(misalign_err), 64'(0));
        @(posedge clk); #1 idle_inputs();
        #3 check("mis_pulse", 64'(misalign_err), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        check("mis_pulses",   64'(mis_cnt),   64'(1));
        check("mis_req_cnt",  64'(req_cnt),   64'(0));
        check("mis_stall_cnt",64'(stall_cnt), 64'(0));

        // Load with no ack: timeout abort.
        mem_txn(1, 0, 32'h0000_0300, 32'h0, 5'd9, 1, 1, 32'h0000_1010, -1, 32'h0);
        alu_op(32'h0000_0077, 5'd4, 32'h0000_1014);

        // Read and write both set: behaves as a load.
        mem_txn(1, 1, 32'h0000_0400, 32'h1111_2222, 5'd6, 1, 1, 32'h0000_1018, 1, 32'hCAFE_F00D);

        // Reset in the middle of BUSY abandons the access.
        clear_cnts();
        exp_mem_addr = 32'h0000_0500; exp_mem_we = 0; exp_mem_wdata = 32'h0;
        set_op(1, 0, 32'h0000_0500, 32'h0, 5'd2, 1, 1, 32'h0000_101C);
        @(posedge clk);
        #3;
        check("busy_req",   64'(mem_req),   64'(1));
        check("busy_stall", 64'(stall_out), 64'(1));
        #1 rst_n = 0;
        #1;
        check("arst_req",   64'(mem_req),   64'(0));
        check("arst_stall", 64'(stall_out), 64'(0));
        check("arst_valid", 64'(valid_out), 64'(0));
        check("arst_addr",  64'(mem_addr),  64'(0));
        idle_inputs();
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1;
        mem_ack = 1; mem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1 mem_ack = 0;
        for (int i = 0; i < 2; i++) begin
            #3;
            check("late_ack_valid", 64'(valid_out), 64'(0));
            check("late_ack_req",   64'(mem_req),   64'(0));
            check("late_ack_stall", 64'(stall_out), 64'(0));
            @(posedge clk); #1;
        end
        alu_op(32'h0000_0099, 5'd8, 32'h0000_1020);
        repeat (2) @(posedge clk);
        #1 check("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the five-stage pipeline, between the EX/MEM register (upstream) and the MEM/WB register (downstream).
- Performs loads and stores over a req/ack data-memory port.
- Stalls the upstream stages while an access is outstanding.
- Presents the write-back bundle (w_data, w_addr, wen, MemtoReg, readMem, PC) to MEM/WB with a valid qualifier.
- Non-memory instructions pass through in zero cycles.

Parameters:
DSIZE, 32, data width
ASIZE, 5, register-file address width
ISIZE, 32, PC width
TIMEOUT, 16, max BUSY cycles waiting for mem_ack before abort (≥2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
valid_in  in  1  EX/MEM holds a live instruction
MemRead_in  in  1  load
MemWrite_in  in  1  store
alu_result_in  in  DSIZE  memory address (load/store) or result (others)
store_data_in  in  DSIZE  store data
w_addr_in  in  ASIZE  destination register
wen_in  in  1  register write enable
MemtoReg_in  in  1  write-back selects memory data
PC_in  in  ISIZE  instruction PC
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  DSIZE  word address, latched
mem_wdata  out  DSIZE  write data, latched
mem_ack  in  1  access complete, 1-cycle pulse
mem_rdata  in  DSIZE  read data, valid with mem_ack
stall_out  out  1  freeze PC/IF-ID/ID-EX/EX-MEM
valid_out  out  1  outputs below are a live instruction for MEM/WB
w_data_out  out  DSIZE  alu_result_in pass-through
w_addr_out  out  ASIZE  w_addr_in pass-through
wen_out  out  1  wen_in & valid_out & ~err
MemtoReg_out  out  1  MemtoReg_in pass-through
readMem_out  out  DSIZE  captured load data, 0 if not a load
PC_out  out  ISIZE  PC_in pass-through
misalign_err  out  1  1-cycle pulse: addr[1:0]≠0 on a memory op
bus_err  out  1  1-cycle pulse: timeout abort

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, read-data capture=0, timeout counter=0, misalign_err=0, bus_err=0. While rst=0: stall_out=0, valid_out=0, wen_out=0.
- FSM states: IDLE, BUSY, DONE.
- mem_req=1 exactly in BUSY. mem_we, mem_addr, mem_wdata are registered and stable for all of BUSY.
- IDLE, valid_in=0: valid_out=0, stall_out=0.
- IDLE, valid_in=1, no MemRead/MemWrite: valid_out=1, stall_out=0, readMem_out=0, combinational pass-through (zero added latency).
- IDLE, valid_in=1, MemRead|MemWrite, addr[1:0]≠0:
  - No request; valid_out=1, wen_out=0, stall_out=0.
  - misalign_err pulses high the next cycle.
- IDLE, valid_in=1, MemRead|MemWrite, aligned:
  - stall_out=1, valid_out=0.
  - On the edge: latch addr/wdata/we (we=MemWrite_in), clear counter, go to BUSY.
  - If MemRead and MemWrite are both set, it is treated as a read.
- BUSY: stall_out=1, valid_out=0; counter increments each cycle.
  - mem_ack=1: capture mem_rdata (loads only; stores capture 0), go to DONE.
  - Counter reaches TIMEOUT-1 with no ack: drop mem_req, bus_err pulses next cycle, go to DONE with error flag set.
- DONE (exactly 1 cycle):
  - stall_out=0, valid_out=1, readMem_out=captured data.
  - wen_out=0 if error flag set.
  - Always returns to IDLE; MEM/WB captures on this edge and EX/MEM advances.
- Latency: ack arriving k cycles after mem_req rises (k=0 = first BUSY cycle) gives k+2 stall cycles, then 1 DONE cycle.
- mem_ack outside BUSY is ignored. mem_rdata is sampled only with mem_ack.
- EX/MEM inputs must hold steady while stall_out=1. The stage itself samples them only in IDLE and DONE.
- Async reset in BUSY drops mem_req the same instant. The in-flight access is abandoned; no valid_out is ever produced for it.

Test Plan:
- Reset, then ALU op (valid_in=1, alu_result_in=0x0000_0042, wen_in=1, w_addr_in=3) -> same cycle: valid_out=1, w_data_out=0x42, wen_out=1, stall_out=0, mem_req=0.
- Load addr 0x100, ack 2 cycles after mem_req rises, mem_rdata=0xDEAD_BEEF -> stall_out high 4 cycles, then DONE cycle with valid_out=1, readMem_out=0xDEADBEEF, mem_we=0, mem_addr=0x100 throughout BUSY.
- Store addr 0x204, data 0x1234_5678, ack in first BUSY cycle -> mem_we=1, mem_wdata=0x12345678; stall 2 cycles; DONE readMem_out=0.
- Load addr 0x103 -> no mem_req, valid_out=1, wen_out=0, misalign_err pulses once.
- Load with no ack, TIMEOUT=16 -> mem_req high exactly 16 cycles, bus_err pulses once, DONE with wen_out=0; a later ALU op passes through normally.
- rst driven low mid-BUSY -> mem_req and stall_out fall immediately; after release, state=IDLE and a late mem_ack is ignored (valid_out stays 0).
